// File: rtl/cmul_pipe.sv
// Four-stage pipelined complex multiplier. A and B streams are joined into one beat.
// The result is optionally multiplied by conj(B), then rounded, shifted and saturated.
module cmul_pipe #(
    parameter int WIDTH_A   = 16,
    parameter int WIDTH_B   = 16,
    parameter int WIDTH_OUT = 16,
    parameter int SCALE     = 15,
    parameter int ROUND     = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [2*WIDTH_A-1:0]   a_tdata,
    input  logic                   a_tlast,
    input  logic                   a_tvalid,
    output logic                   a_tready,
    input  logic [2*WIDTH_B-1:0]   b_tdata,
    input  logic                   b_tlast,
    input  logic                   b_tvalid,
    output logic                   b_tready,
    input  logic                   conj,
    output logic [2*WIDTH_OUT-1:0] o_tdata,
    output logic                   o_tlast,
    output logic                   o_tvalid,
    input  logic                   o_tready,
    output logic                   sat_flag,
    input  logic                   sat_clear
);

    localparam int PW  = WIDTH_A + WIDTH_B;
    localparam int FW  = PW + 1;
    // One guard bit above full precision so the rounding add cannot wrap.
    localparam int RW  = FW + 1;
    localparam int RSH = (SCALE > 0) ? SCALE - 1 : 0;
    localparam logic signed [RW-1:0] RND_ADD =
        (ROUND != 0 && SCALE > 0) ? (RW'(1) << RSH) : RW'(0);

    logic enable;
    logic in_xfer;
    logic unused_b_tlast;

    logic                        s1_valid_q, s1_valid_d;
    logic                        s1_last_q, s1_last_d;
    logic                        s1_conj_q, s1_conj_d;
    logic signed [WIDTH_A-1:0]   s1_ai_q, s1_ai_d, s1_aq_q, s1_aq_d;
    logic signed [WIDTH_B-1:0]   s1_bi_q, s1_bi_d, s1_bq_q, s1_bq_d;

    logic                        s2_valid_q, s2_valid_d;
    logic                        s2_last_q, s2_last_d;
    logic                        s2_conj_q, s2_conj_d;
    logic signed [PW-1:0]        s2_pii_q, s2_pii_d, s2_pqq_q, s2_pqq_d;
    logic signed [PW-1:0]        s2_pqi_q, s2_pqi_d, s2_piq_q, s2_piq_d;

    logic                        s3_valid_q, s3_valid_d;
    logic                        s3_last_q, s3_last_d;
    logic signed [FW-1:0]        s3_re_q, s3_re_d, s3_im_q, s3_im_d;

    logic                        s4_valid_q, s4_valid_d;
    logic                        s4_last_q, s4_last_d;
    logic [WIDTH_OUT-1:0]        s4_re_q, s4_re_d, s4_im_q, s4_im_d;

    logic                        sat_flag_q, sat_flag_d;
    logic                        clip_re, clip_im;
    logic [WIDTH_OUT-1:0]        sat_re, sat_im;

    // Returns {clipped, value}: round, arithmetic shift, then clamp to the output range.
    function automatic logic [WIDTH_OUT:0] scale_sat(input logic signed [FW-1:0] v);
        logic signed [RW-1:0]   r;
        logic [RW-WIDTH_OUT:0]  hi;
        logic [WIDTH_OUT:0]     res;
        r  = (RW'(v) + RND_ADD) >>> SCALE;
        hi = r[RW-1:WIDTH_OUT-1];
        if ((&hi) || !(|hi)) begin
            res = {1'b0, r[WIDTH_OUT-1:0]};
        end else begin
            res = {1'b1, r[RW-1], {(WIDTH_OUT-1){~r[RW-1]}}};
        end
        return res;
    endfunction

    assign unused_b_tlast = b_tlast;
    assign enable   = ~s4_valid_q | o_tready;
    assign in_xfer  = a_tvalid & b_tvalid & enable & ~reset;
    assign a_tready = in_xfer;
    assign b_tready = in_xfer;

    assign o_tdata  = reset ? '0 : {s4_re_q, s4_im_q};
    assign o_tlast  = s4_last_q;
    assign o_tvalid = s4_valid_q;
    assign sat_flag = sat_flag_q;

    always_comb begin
        {clip_re, sat_re} = scale_sat(s3_re_q);
        {clip_im, sat_im} = scale_sat(s3_im_q);

        s1_valid_d = s1_valid_q;
        s1_last_d  = s1_last_q;
        s1_conj_d  = s1_conj_q;
        s1_ai_d    = s1_ai_q;
        s1_aq_d    = s1_aq_q;
        s1_bi_d    = s1_bi_q;
        s1_bq_d    = s1_bq_q;
        s2_valid_d = s2_valid_q;
        s2_last_d  = s2_last_q;
        s2_conj_d  = s2_conj_q;
        s2_pii_d   = s2_pii_q;
        s2_pqq_d   = s2_pqq_q;
        s2_pqi_d   = s2_pqi_q;
        s2_piq_d   = s2_piq_q;
        s3_valid_d = s3_valid_q;
        s3_last_d  = s3_last_q;
        s3_re_d    = s3_re_q;
        s3_im_d    = s3_im_q;
        s4_valid_d = s4_valid_q;
        s4_last_d  = s4_last_q;
        s4_re_d    = s4_re_q;
        s4_im_d    = s4_im_q;

        if (enable) begin
            s1_valid_d = a_tvalid & b_tvalid;
            s1_last_d  = a_tlast;
            s1_conj_d  = conj;
            s1_ai_d    = a_tdata[2*WIDTH_A-1:WIDTH_A];
            s1_aq_d    = a_tdata[WIDTH_A-1:0];
            s1_bi_d    = b_tdata[2*WIDTH_B-1:WIDTH_B];
            s1_bq_d    = b_tdata[WIDTH_B-1:0];

            s2_valid_d = s1_valid_q;
            s2_last_d  = s1_last_q;
            s2_conj_d  = s1_conj_q;
            s2_pii_d   = PW'(s1_ai_q) * PW'(s1_bi_q);
            s2_pqq_d   = PW'(s1_aq_q) * PW'(s1_bq_q);
            s2_pqi_d   = PW'(s1_aq_q) * PW'(s1_bi_q);
            s2_piq_d   = PW'(s1_ai_q) * PW'(s1_bq_q);

            s3_valid_d = s2_valid_q;
            s3_last_d  = s2_last_q;
            if (s2_conj_q) begin
                s3_re_d = FW'(s2_pii_q) + FW'(s2_pqq_q);
                s3_im_d = FW'(s2_pqi_q) - FW'(s2_piq_q);
            end else begin
                s3_re_d = FW'(s2_pii_q) - FW'(s2_pqq_q);
                s3_im_d = FW'(s2_pqi_q) + FW'(s2_piq_q);
            end

            s4_valid_d = s3_valid_q;
            s4_last_d  = s3_last_q;
            s4_re_d    = sat_re;
            s4_im_d    = sat_im;
        end

        // A clip landing in the same cycle as sat_clear keeps the flag set.
        sat_flag_d = (enable & s3_valid_q & (clip_re | clip_im)) | (sat_flag_q & ~sat_clear);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_last_q  <= 1'b0;
            s3_valid_q <= 1'b0;
            s3_last_q  <= 1'b0;
            s4_valid_q <= 1'b0;
            s4_last_q  <= 1'b0;
            s4_re_q    <= '0;
            s4_im_q    <= '0;
            sat_flag_q <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_last_q  <= s1_last_d;
            s2_valid_q <= s2_valid_d;
            s2_last_q  <= s2_last_d;
            s3_valid_q <= s3_valid_d;
            s3_last_q  <= s3_last_d;
            s4_valid_q <= s4_valid_d;
            s4_last_q  <= s4_last_d;
            s4_re_q    <= s4_re_d;
            s4_im_q    <= s4_im_d;
            sat_flag_q <= sat_flag_d;
        end
    end

    // Datapath registers need no reset; the valid bits qualify them.
    always_ff @(posedge clk) begin
        s1_conj_q <= s1_conj_d;
        s1_ai_q   <= s1_ai_d;
        s1_aq_q   <= s1_aq_d;
        s1_bi_q   <= s1_bi_d;
        s1_bq_q   <= s1_bq_d;
        s2_conj_q <= s2_conj_d;
        s2_pii_q  <= s2_pii_d;
        s2_pqq_q  <= s2_pqq_d;
        s2_pqi_q  <= s2_pqi_d;
        s2_piq_q  <= s2_piq_d;
        s3_re_q   <= s3_re_d;
        s3_im_q   <= s3_im_d;
    end

endmodule

// File: tb/tb_cmul_pipe.sv
// Bench for cmul_pipe: directed steps plus a randomized join/backpressure stream.
// Two instances are used, one rounding and one truncating, both on the same inputs.
module tb_cmul_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [31:0] a_tdata, b_tdata;
    logic        a_tlast, a_tvalid, b_tlast, b_tvalid, conj, o_tready, sat_clear;
    logic        a_tready, b_tready, o_tlast, o_tvalid, sat_flag;
    logic [31:0] o_tdata;
    logic        a2_tready, b2_tready, o2_tlast, o2_tvalid, sat2_flag;
    logic [31:0] o2_tdata;

    cmul_pipe dut (
        .clk(clk), .reset(reset),
        .a_tdata(a_tdata), .a_tlast(a_tlast), .a_tvalid(a_tvalid), .a_tready(a_tready),
        .b_tdata(b_tdata), .b_tlast(b_tlast), .b_tvalid(b_tvalid), .b_tready(b_tready),
        .conj(conj),
        .o_tdata(o_tdata), .o_tlast(o_tlast), .o_tvalid(o_tvalid), .o_tready(o_tready),
        .sat_flag(sat_flag), .sat_clear(sat_clear)
    );

    cmul_pipe #(.ROUND(0)) dut_trunc (
        .clk(clk), .reset(reset),
        .a_tdata(a_tdata), .a_tlast(a_tlast), .a_tvalid(a_tvalid), .a_tready(a2_tready),
        .b_tdata(b_tdata), .b_tlast(b_tlast), .b_tvalid(b_tvalid), .b_tready(b2_tready),
        .conj(conj),
        .o_tdata(o2_tdata), .o_tlast(o2_tlast), .o_tvalid(o2_tvalid), .o_tready(o_tready),
        .sat_flag(sat2_flag), .sat_clear(sat_clear)
    );

    typedef struct {
        logic [31:0] d1;
        logic [31:0] d2;
        logic        last;
        int          cyc;
    } exp_t;

    exp_t        exp_q[$];
    int          checks  = 0;
    int          errors  = 0;
    int          cyc     = 0;
    int          out_cnt = 0;
    bit          xfer_now, lat_chk, any_clip, stalled;
    logic [33:0] held;

    localparam int NB = 150;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Complex product in plain integer arithmetic, Q15 scaling, 16-bit saturation.
    function automatic logic [15:0] scale_sat(input longint v, input bit rnd, output bit c);
        longint s;
        s = (v + (rnd ? 64'sd16384 : 64'sd0)) >>> 15;
        c = (s > 32767) || (s < -32768);
        if (s > 32767) s = 32767;
        else if (s < -32768) s = -32768;
        return s[15:0];
    endfunction

    function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic cj, input bit rnd, output bit clip);
        longint ai, aq, bi, bq, re, im;
        bit     c_re, c_im;
        logic [15:0] r_re, r_im;
        ai = longint'($signed(a[31:16]));
        aq = longint'($signed(a[15:0]));
        bi = longint'($signed(b[31:16]));
        bq = longint'($signed(b[15:0]));
        if (cj) begin
            re = ai * bi + aq * bq;
            im = aq * bi - ai * bq;
        end else begin
            re = ai * bi - aq * bq;
            im = aq * bi + ai * bq;
        end
        r_re = scale_sat(re, rnd, c_re);
        r_im = scale_sat(im, rnd, c_im);
        clip = c_re | c_im;
        return {r_re, r_im};
    endfunction

    // One clock: observe handshakes at the falling edge, return just after the rising edge.
    task automatic tick();
        exp_t e;
        bit   c1, c2;
        xfer_now = 1'b0;
        @(negedge clk);
        cyc++;
        if (reset) begin
            chk("ready_in_reset", {a_tready, b_tready}, 0);
            exp_q.delete();
            stalled = 1'b0;
        end else begin
            chk("trunc_valid", o2_tvalid, o_tvalid);
            if (stalled) chk("stall_hold", {o_tvalid, o_tlast, o_tdata}, held);
            if (a_tvalid && b_tvalid && a_tready) begin
                chk("ready_match", b_tready, a_tready);
                e.d1 = model(a_tdata, b_tdata, conj, 1'b1, c1);
                e.d2 = model(a_tdata, b_tdata, conj, 1'b0, c2);
                e.last = a_tlast;
                e.cyc  = cyc;
                any_clip |= c1;
                exp_q.push_back(e);
                xfer_now = 1'b1;
            end
            if (o_tvalid && o_tready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $error("FAIL unexpected_out: observed o_tvalid=1 required no beat in flight");
                end else begin
                    e = exp_q.pop_front();
                    chk("o_tdata", o_tdata, e.d1);
                    chk("o_tdata_trunc", o2_tdata, e.d2);
                    chk("o_tlast", o_tlast, e.last);
                    if (lat_chk) chk("latency", cyc - e.cyc, 4);
                    out_cnt++;
                end
            end
            stalled = o_tvalid && !o_tready;
            held    = {o_tvalid, o_tlast, o_tdata};
        end
        @(posedge clk);
        #1;
    endtask

    // Single beat with o_tready high; returns in the cycle the result should be valid.
    task automatic send4(input logic [31:0] a, input logic [31:0] b, input logic cj);
        a_tdata = a; b_tdata = b; conj = cj; a_tlast = 1'b1;
        a_tvalid = 1'b1; b_tvalid = 1'b1;
        tick();
        chk("xfer", xfer_now, 1);
        a_tvalid = 1'b0; b_tvalid = 1'b0; a_tlast = 1'b0;
        tick();
        tick();
        chk("pre_valid", o_tvalid, 0);
        tick();
    endtask

    initial begin
        int sent;
        int guard;
        reset = 1'b1; a_tdata = '0; b_tdata = '0; a_tlast = 1'b0; b_tlast = 1'b0;
        a_tvalid = 1'b0; b_tvalid = 1'b0; conj = 1'b0; o_tready = 1'b1; sat_clear = 1'b0;
        lat_chk = 1'b1; any_clip = 1'b0; stalled = 1'b0; held = '0;
        @(posedge clk);
        #1;
        a_tvalid = 1'b1; b_tvalid = 1'b1;
        tick();
        tick();
        a_tvalid = 1'b0; b_tvalid = 1'b0;
        reset = 1'b0;
        chk("rst_o_tvalid", o_tvalid, 0);
        chk("rst_o_tlast", o_tlast, 0);
        chk("rst_sat_flag", sat_flag, 0);
        chk("rst_o_tdata", o_tdata, 0);

        send4(32'h4000_0000, 32'h4000_4000, 1'b0);
        chk("basic_valid", o_tvalid, 1);
        chk("basic_data", o_tdata, 32'h2000_2000);
        chk("basic_last", o_tlast, 1);
        tick();

        send4(32'h8000_8000, 32'h8000_8000, 1'b0);
        chk("sat_data", o_tdata, 32'h0000_7fff);
        tick();
        chk("sat_flag_set", sat_flag, 1);
        send4(32'h8000_8000, 32'h8000_8000, 1'b1);
        chk("conj_data", o_tdata, 32'h7fff_0000);
        tick();

        send4(32'h0001_0000, 32'h4000_0000, 1'b0);
        chk("round_i", o_tdata, 32'h0001_0000);
        chk("trunc_i", o2_tdata, 32'h0000_0000);
        tick();

        sat_clear = 1'b1;
        tick();
        sat_clear = 1'b0;
        chk("clear_alone", sat_flag, 0);

        a_tdata = 32'h8000_8000; b_tdata = 32'h8000_8000; conj = 1'b0;
        a_tvalid = 1'b1; b_tvalid = 1'b1;
        tick();
        a_tvalid = 1'b0; b_tvalid = 1'b0;
        tick();
        tick();
        sat_clear = 1'b1;
        tick();
        sat_clear = 1'b0;
        chk("clear_vs_clip", sat_flag, 1);
        chk("clip_valid", o_tvalid, 1);
        tick();

        a_tvalid = 1'b1; b_tvalid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a_tdata = $urandom; b_tdata = $urandom; conj = 1'($urandom_range(0, 1));
            tick();
        end
        reset = 1'b1;
        #1;
        chk("rst_mid_o_tdata", o_tdata, 0);
        tick();
        reset = 1'b0;
        a_tvalid = 1'b0; b_tvalid = 1'b0;
        chk("rst_mid_sat_flag", sat_flag, 0);
        for (int i = 0; i < 4; i++) begin
            chk("post_rst_quiet", o_tvalid, 0);
            tick();
        end
        send4($urandom, $urandom, 1'b0);
        chk("post_rst_latency", o_tvalid, 1);
        tick();

        sat_clear = 1'b1;
        tick();
        sat_clear = 1'b0;
        any_clip = 1'b0;
        lat_chk  = 1'b0;
        out_cnt  = 0;
        sent     = 0;
        guard    = 0;
        a_tdata = $urandom; b_tdata = $urandom; conj = 1'($urandom_range(0, 1));
        a_tlast = 1'b0; b_tlast = 1'($urandom_range(0, 1));
        while (out_cnt < NB && guard < 4000) begin
            a_tvalid = (sent < NB);
            b_tvalid = (sent < NB) && (guard % 2 == 0);
            o_tready = ($urandom_range(0, 3) != 0);
            tick();
            guard++;
            if (xfer_now) begin
                sent++;
                a_tdata = $urandom; b_tdata = $urandom; conj = 1'($urandom_range(0, 1));
                a_tlast = (sent % 5 == 4);
                b_tlast = 1'($urandom_range(0, 1));
            end
        end
        a_tvalid = 1'b0; b_tvalid = 1'b0; o_tready = 1'b1;
        chk("beats_in", sent, NB);
        chk("beats_out", out_cnt, NB);
        chk("queue_empty", exp_q.size(), 0);
        tick();
        chk("sat_flag_stream", sat_flag, any_clip);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cmul_pipe.md
CMUL_PIPE -- requirements
Module: cmul_pipe

Interface
REQ-001 SHALL have parameter WIDTH_A, default 16: signed width of each I/Q component on input A.
REQ-002 SHALL have parameter WIDTH_B, default 16: signed width of each I/Q component on input B.
REQ-003 SHALL have parameter WIDTH_OUT, default 16: signed width of each I/Q component on the output.
REQ-004 SHALL have parameter SCALE, default 15: right-shift applied to the full-precision result; legal range 0..WIDTH_A+WIDTH_B.
REQ-005 SHALL have parameter ROUND, default 1: 1 = round half up, 0 = truncate toward minus infinity.
REQ-006 SHALL have port clk, input, 1 bit: the single clock.
REQ-007 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-008 SHALL have port a_tdata, input, 2*WIDTH_A bits: {I, Q}, I in the upper half.
REQ-009 SHALL have ports a_tlast/a_tvalid (input, 1 bit) and a_tready (output, 1 bit): AXI-stream handshake for A.
REQ-010 SHALL have port b_tdata, input, 2*WIDTH_B bits: {I, Q}, I in the upper half.
REQ-011 SHALL have ports b_tlast/b_tvalid (input, 1 bit) and b_tready (output, 1 bit): AXI-stream handshake for B; b_tlast is ignored.
REQ-012 SHALL have port conj, input, 1 bit: per-beat flag, sampled on the input transfer; 1 = multiply A by conj(B).
REQ-013 SHALL have port o_tdata, output, 2*WIDTH_OUT bits: {I, Q} result.
REQ-014 SHALL have ports o_tlast/o_tvalid (output, 1 bit) and o_tready (input, 1 bit): output handshake.
REQ-015 SHALL have port sat_flag, output, 1 bit: sticky indicator that saturation has occurred.
REQ-016 SHALL have port sat_clear, input, 1 bit: clears sat_flag.

Function
REQ-017 SHALL join inputs: an input transfer occurs only when a_tvalid=1, b_tvalid=1, and the pipeline enable is 1.
REQ-018 SHALL drive a_tready = b_tready = a_tvalid & b_tvalid & enable, so neither input is consumed alone.
REQ-019 SHALL implement a 4-stage pipeline: S1 registers the inputs, S2 forms four products, S3 forms the sum and difference, S4 rounds and clips.
REQ-020 SHALL compute enable = ~o_tvalid | o_tready; all stages advance together on enable, and each stage carries a valid bit.
REQ-021 SHALL give a latency of exactly 4 cycles from input transfer to o_tvalid when o_tready is held at 1.
REQ-022 SHALL sustain a throughput of one beat per cycle while both inputs are valid and o_tready=1.
REQ-023 SHALL hold o_tdata, o_tlast and o_tvalid stable while o_tvalid=1 and o_tready=0.
REQ-024 SHALL compute, for conj=0: I = aI*bI - aQ*bQ and Q = aQ*bI + aI*bQ.
REQ-025 SHALL compute, for conj=1: I = aI*bI + aQ*bQ and Q = aQ*bI - aI*bQ.
REQ-026 SHALL form products and sums at full precision, WIDTH_A+WIDTH_B+1 bits, with no intermediate overflow.
REQ-027 SHALL, for ROUND=1 and SCALE>0, add 2^(SCALE-1) before an arithmetic right shift by SCALE.
REQ-028 SHALL, for ROUND=0 or SCALE=0, perform the arithmetic right shift only.
REQ-029 SHALL saturate each shifted component to [-2^(WIDTH_OUT-1), 2^(WIDTH_OUT-1)-1].
REQ-030 SHALL set sat_flag on the cycle after any S4 beat clips I or Q while enable=1.
REQ-031 SHALL, when sat_clear and a new clip event coincide, leave sat_flag set (set wins).
REQ-032 SHALL carry a_tlast through the pipeline in lockstep with the data it accompanies, emerging as o_tlast.
REQ-033 SHALL carry conj through the pipeline in lockstep with the data it accompanies.
REQ-034 SHALL let bubbles pass through the pipeline without producing o_tvalid.

Reset
REQ-035 SHALL, on reset=1 at a clock edge, clear all stage valid bits, o_tvalid, o_tlast and sat_flag.
REQ-036 SHALL drive o_tdata to 0 while in reset.
REQ-037 SHALL hold a_tready = b_tready = 0 during the reset cycle.
REQ-038 SHALL discard in-flight beats on a reset asserted mid-stream; none emerge after reset.

Verification
REQ-039 SHALL verify basic multiply (defaults): a=(0x4000,0x0000), b=(0x4000,0x4000), conj=0 -> o_tdata={0x2000,0x2000} exactly 4 cycles later.
REQ-040 SHALL verify saturation and conjugate: a=b=(0x8000,0x8000); conj=0 -> {0x0000,0x7FFF} with sat_flag=1; conj=1 -> {0x7FFF,0x0000}.
REQ-041 SHALL verify rounding: a=(0x0001,0x0000), b=(0x4000,0x0000) -> I=0x0001 when ROUND=1, I=0x0000 when ROUND=0.
REQ-042 SHALL verify the join and backpressure: B valid only on alternate cycles with random o_tready -> no A beat lost or duplicated, output order preserved, o_tlast on the correct beat.
REQ-043 SHALL verify mid-stream reset: reset pulsed with 3 beats in flight -> no o_tvalid in the 4 cycles after reset, and the next beat has correct latency.
REQ-044 SHALL verify sat_clear: sat_clear asserted coincident with a clip -> sat_flag stays 1; sat_clear asserted alone -> sat_flag reads 0 the next cycle.
